// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the full_adder block.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    typedef struct packed {
        logic                    c_out;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_half_adder.sv
// Single-bit half adder; two of these plus an OR form one full-adder bit.
module half_adder (
    input  logic a,
    input  logic b,
    output logic out,
    output logic carry
);

    assign out   = a ^ b;
    assign carry = a & b;

endmodule : half_adder

// File: rtl/full_adder.sv
// Ripple-carry adder with a single output register stage.
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
        $error("full_adder: WIDTH out of range 1..64");
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] ha_prop;
    logic [WIDTH-1:0] ha_gen_ab;
    logic [WIDTH-1:0] ha_gen_c;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = c_in;

    // Each bit: first half adder combines operands, second folds in the incoming carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_adder u_ha_ab (
            .a     (a[i]),
            .b     (b[i]),
            .out   (ha_prop[i]),
            .carry (ha_gen_ab[i])
        );

        half_adder u_ha_c (
            .a     (ha_prop[i]),
            .b     (carry[i]),
            .out   (sum_next[i]),
            .carry (ha_gen_c[i])
        );

        assign carry[i+1] = ha_gen_ab[i] | ha_gen_c[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_next;
                c_out <= carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    logic ovf_next;

    assign ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed-vector bench for full_adder at WIDTH=1 and WIDTH=8.
// Overflow checks are compiled in when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

    logic       clk;
    logic       rst_n;

    logic       v1, a1, b1, c1;
    logic       vo1, s1, co1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       vo8, co8;
    logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf8;
`endif

    int checks;
    int errors;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c_in      (c1),
        .out_valid (vo1),
        .sum       (s1),
        .c_out     (co1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .c_in      (c8),
        .out_valid (vo8),
        .sum       (s8),
        .c_out     (co8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic exp_s;
        logic exp_co;
    } tt_vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_s;
        logic       exp_co;
        logic       exp_ovf;
    } w8_vec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then return just after the next rising edge.
    task automatic applyStimulus(input logic v1i, input logic a1i, input logic b1i, input logic c1i,
                                 input logic v8i, input logic [7:0] a8i, input logic [7:0] b8i,
                                 input logic c8i);
        @(negedge clk);
        v1 = v1i; a1 = a1i; b1 = b1i; c1 = c1i;
        v8 = v8i; a8 = a8i; b8 = b8i; c8 = c8i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vo1"}, 64'(vo1), 64'd0);
        checkOutput({tag, "_s1"},  64'(s1),  64'd0);
        checkOutput({tag, "_co1"}, 64'(co1), 64'd0);
        checkOutput({tag, "_vo8"}, 64'(vo8), 64'd0);
        checkOutput({tag, "_s8"},  64'(s8),  64'd0);
        checkOutput({tag, "_co8"}, 64'(co8), 64'd0);
`ifdef FULL_ADDER_OVF_EN
        checkOutput({tag, "_ovf1"}, 64'(ovf1), 64'd0);
        checkOutput({tag, "_ovf8"}, 64'(ovf8), 64'd0);
`endif
    endtask

    tt_vec_t tt[8];
    w8_vec_t w8[9];

    initial begin
        checks = 0;
        errors = 0;

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        w8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        w8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        w8[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        w8[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        w8[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        w8[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        w8[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        w8[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        w8[8] = '{8'h1E, 8'h1E, 1'b0, 8'h3C, 1'b0, 1'b0};

        rst_n = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

        // Reset asserted before any clock edge must clear outputs on its own.
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkAllZero("post_release");

        $display("[TB] WIDTH=1 truth table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, tt[i].a, tt[i].b, tt[i].c, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput($sformatf("tt%0d_vo", i), 64'(vo1), 64'd1);
            checkOutput($sformatf("tt%0d_s", i),  64'(s1),  64'(tt[i].exp_s));
            checkOutput($sformatf("tt%0d_co", i), 64'(co1), 64'(tt[i].exp_co));
        end

        $display("[TB] WIDTH=8 back-to-back vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w8[i].a, w8[i].b, w8[i].c);
            checkOutput($sformatf("w8_%0d_vo", i), 64'(vo8), 64'd1);
            checkOutput($sformatf("w8_%0d_s", i),  64'(s8),  64'(w8[i].exp_s));
            checkOutput($sformatf("w8_%0d_co", i), 64'(co8), 64'(w8[i].exp_co));
`ifdef FULL_ADDER_OVF_EN
            checkOutput($sformatf("w8_%0d_ovf", i), 64'(ovf8), 64'(w8[i].exp_ovf));
`endif
        end
        checkOutput("w1_idle_vo", 64'(vo1), 64'd0);

        // Idle cycles with garbage operands must not disturb the held result.
        $display("[TB] WIDTH=8 hold with in_valid low");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h77, 1'b1);
            checkOutput($sformatf("hold%0d_vo", i), 64'(vo8), 64'd0);
            checkOutput($sformatf("hold%0d_s", i),  64'(s8),  64'h3C);
            checkOutput($sformatf("hold%0d_co", i), 64'(co8), 64'd0);
            checkOutput($sformatf("hold%0d_s1", i), 64'(s1),  64'd1);
        end

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        checkOutput("pre_rst_vo8", 64'(vo8), 64'd1);
        checkOutput("pre_rst_s8",  64'(s8),  64'h80);
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_rst");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        checkAllZero("in_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        checkAllZero("rst_discard");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
        checkOutput("after_rst_vo8", 64'(vo8), 64'd1);
        checkOutput("after_rst_s8",  64'(s8),  64'h47);
        checkOutput("after_rst_co8", 64'(co8), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  operands and c_in on this cycle are to be added.
REQ-005 Port: a  input  WIDTH  first operand; bit 0 is the LSB.
REQ-006 Port: b  input  WIDTH  second operand.
REQ-007 Port: c_in  input  1  carry into bit 0.
REQ-008 Port: out_valid  output  1  sum/c_out hold a new result this cycle.
REQ-009 Port: sum  output  WIDTH  registered sum bits.
REQ-010 Port: c_out  output  1  registered carry out of bit WIDTH-1.
REQ-011 Port (only with FULL_ADDER_OVF_EN): ovf  output  1  registered two's-complement signed overflow.

Function
REQ-012 The block SHALL compute {c_out, sum} = a + b + c_in as an unsigned (WIDTH+1)-bit result, with no truncation before the final carry.
REQ-013 Each bit i SHALL use full-adder logic: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = c_in.
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on sum/c_out with out_valid=1 after edge N.
REQ-015 out_valid SHALL be a registered copy of in_valid; there is no backpressure, and a new operation is accepted every cycle.
REQ-016 When in_valid=0, sum/c_out (and ovf) SHALL hold their previous values, and out_valid SHALL be 0 in the following cycle.
REQ-017 The carry chain SHALL be purely combinational ripple with no internal pipeline stages and no state machine.
REQ-018 Boundary, all ones: a=b=all-ones, c_in=1 SHALL give sum=all-ones, c_out=1.
REQ-019 Boundary, wrap-around: a=all-ones, b=0, c_in=1 SHALL give sum=0, c_out=1.
REQ-020 With WIDTH=1, the outputs SHALL match the 8-row full-adder truth table exactly.

Reset
REQ-021 While rst_n=0, out_valid, sum, c_out and ovf SHALL all be 0, asynchronously and regardless of clk.
REQ-022 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first valid result appears one cycle after the first sampled in_valid=1.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight result; out_valid SHALL be 0 on the first cycle after release unless in_valid was sampled high at that edge.

Configuration
REQ-024 Macro FULL_ADDER_OVF_EN defined: port ovf SHALL exist and be registered, equal to (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), updating and holding under the same rules as sum.
REQ-025 FULL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package full_adder_pkg SHALL hold FA_DEFAULT_WIDTH (=1), FA_MAX_WIDTH (=64) and the typedef fa_result_t (packed struct: c_out, sum).
REQ-027 Sub-module half_adder (combinational; ports a, b -> out = a^b, carry = a&b) SHALL be instantiated twice per bit.
REQ-028 Per-bit carry SHALL be formed by ORing the two half_adder carries.
REQ-029 The output register SHALL live only in full_adder.

Verification
REQ-030 WIDTH=1, in_valid=1, sweep all 8 {a,b,c_in} combinations -> each result 1 cycle later, e.g. 1,1,1 -> sum=1, c_out=1; 1,0,0 -> sum=1, c_out=0; 0,0,0 -> sum=0, c_out=0.
REQ-031 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, out_valid=1 next cycle.
REQ-032 WIDTH=8, a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-033 WIDTH=8, result 0x3C held, then in_valid=0 for 3 cycles -> sum stays 0x3C and out_valid=0.
REQ-034 WIDTH=8, rst_n driven low between clock edges while out_valid=1 -> all outputs 0 immediately, without waiting for an edge.
REQ-035 FULL_ADDER_OVF_EN, WIDTH=8, a=0x7F, b=0x01, c_in=0 -> sum=0x80, ovf=1, c_out=0.
